// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath width, ALU encodings, ID/EX stage record.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] ALU_TYPE_RI = 2'b00;
  localparam logic [1:0] ALU_TYPE_S  = 2'b01;
  localparam logic [1:0] ALU_TYPE_B  = 2'b10;
  localparam logic [1:0] ALU_TYPE_J  = 2'b11;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_control;
    logic [1:0]      alu_type;
    logic            src_a_pc;
    logic            src_b_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } id_ex_t;

  // A bubble is a fully zeroed record: invalid, no side effects, ALUType RI.
  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/forward_mux.sv
// Three-way priority operand select: EX/MEM result, then MEM/WB result, then register file.
module forward_mux
  import core_pkg::*;
(
  input  logic [4:0]      rs_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic [4:0]      exm_rd_i,
  input  logic            exm_reg_write_i,
  input  logic [XLEN-1:0] exm_result_i,
  input  logic [4:0]      mwb_rd_i,
  input  logic            mwb_reg_write_i,
  input  logic [XLEN-1:0] mwb_result_i,
  output logic [XLEN-1:0] data_o
);

  logic exm_hit;
  logic mwb_hit;

  // x0 is hardwired to zero, so a write targeting it never forwards.
  assign exm_hit = exm_reg_write_i && (exm_rd_i != 5'd0) && (exm_rd_i == rs_i);
  assign mwb_hit = mwb_reg_write_i && (mwb_rd_i != 5'd0) && (mwb_rd_i == rs_i);

  always_comb begin
    data_o = rf_data_i;
    if (exm_hit) begin
      data_o = exm_result_i;
    end else if (mwb_hit) begin
      data_o = mwb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/execute pipeline register with operand forwarding, load-use bubble insertion and ALU operand select.
module id_ex_stage
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic            id_use_rs1_i,
  input  logic            id_use_rs2_i,
  input  logic [3:0]      id_alu_control_i,
  input  logic [1:0]      id_alu_type_i,
  input  logic            id_src_a_pc_i,
  input  logic            id_src_b_imm_i,
  input  logic            id_reg_write_i,
  input  logic            id_mem_read_i,
  input  logic            id_mem_write_i,
  input  logic [4:0]      exm_rd_i,
  input  logic            exm_reg_write_i,
  input  logic [XLEN-1:0] exm_result_i,
  input  logic [4:0]      mwb_rd_i,
  input  logic            mwb_reg_write_i,
  input  logic [XLEN-1:0] mwb_result_i,
  output logic            hazard_o,
  output logic [XLEN-1:0] ScrA,
  output logic [XLEN-1:0] ScrB,
  output logic [3:0]      ALUControl,
  output logic [1:0]      ALUType,
  output logic [XLEN-1:0] ex_store_data_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [4:0]      ex_rd_o,
  output logic            ex_valid_o,
  output logic            ex_reg_write_o,
  output logic            ex_mem_read_o,
  output logic            ex_mem_write_o
);

  id_ex_t          stage_q;
  id_ex_t          stage_d;
  id_ex_t          id_in;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic            dep_rs1;
  logic            dep_rs2;

  assign dep_rs1 = id_use_rs1_i && (id_rs1_i == stage_q.rd);
  assign dep_rs2 = id_use_rs2_i && (id_rs2_i == stage_q.rd);

  // A flushed decode slot is discarded anyway, so it must not stall the front end.
  assign hazard_o = !flush_i && id_valid_i && stage_q.valid && stage_q.mem_read &&
                    (stage_q.rd != 5'd0) && (dep_rs1 || dep_rs2);

  always_comb begin
    id_in             = ID_EX_BUBBLE;
    id_in.valid       = id_valid_i;
    id_in.pc          = id_pc_i;
    id_in.imm         = id_imm_i;
    id_in.rs1_data    = id_rs1_data_i;
    id_in.rs2_data    = id_rs2_data_i;
    id_in.rs1         = id_rs1_i;
    id_in.rs2         = id_rs2_i;
    id_in.rd          = id_rd_i;
    id_in.alu_control = id_alu_control_i;
    id_in.alu_type    = id_alu_type_i;
    id_in.src_a_pc    = id_src_a_pc_i;
    id_in.src_b_imm   = id_src_b_imm_i;
    id_in.reg_write   = id_reg_write_i;
    id_in.mem_read    = id_mem_read_i;
    id_in.mem_write   = id_mem_write_i;
  end

  // Flush beats stall; a stall holding a load in EX also holds the hazard without bubbling.
  always_comb begin
    stage_d = stage_q;
    if (flush_i) begin
      stage_d = ID_EX_BUBBLE;
    end else if (stall_i) begin
      stage_d = stage_q;
    end else if (hazard_o) begin
      stage_d = ID_EX_BUBBLE;
    end else begin
      stage_d = id_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= ID_EX_BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  forward_mux u_fwd_a (
    .rs_i            (stage_q.rs1),
    .rf_data_i       (stage_q.rs1_data),
    .exm_rd_i        (exm_rd_i),
    .exm_reg_write_i (exm_reg_write_i),
    .exm_result_i    (exm_result_i),
    .mwb_rd_i        (mwb_rd_i),
    .mwb_reg_write_i (mwb_reg_write_i),
    .mwb_result_i    (mwb_result_i),
    .data_o          (fwd_a)
  );

  forward_mux u_fwd_b (
    .rs_i            (stage_q.rs2),
    .rf_data_i       (stage_q.rs2_data),
    .exm_rd_i        (exm_rd_i),
    .exm_reg_write_i (exm_reg_write_i),
    .exm_result_i    (exm_result_i),
    .mwb_rd_i        (mwb_rd_i),
    .mwb_reg_write_i (mwb_reg_write_i),
    .mwb_result_i    (mwb_result_i),
    .data_o          (fwd_b)
  );

  assign ScrA            = stage_q.src_a_pc  ? stage_q.pc  : fwd_a;
  assign ScrB            = stage_q.src_b_imm ? stage_q.imm : fwd_b;
  assign ex_store_data_o = fwd_b;
  assign ALUControl      = stage_q.alu_control;
  assign ALUType         = stage_q.alu_type;
  assign ex_pc_o         = stage_q.pc;
  assign ex_rd_o         = stage_q.rd;
  assign ex_valid_o      = stage_q.valid;
  assign ex_reg_write_o  = stage_q.reg_write;
  assign ex_mem_read_o   = stage_q.mem_read;
  assign ex_mem_write_o  = stage_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: reset, forwarding, load-use, flush, stall, store.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, id_valid_i;
  logic [31:0] id_pc_i, id_imm_i, id_rs1_data_i, id_rs2_data_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_use_rs1_i, id_use_rs2_i;
  logic [3:0]  id_alu_control_i;
  logic [1:0]  id_alu_type_i;
  logic        id_src_a_pc_i, id_src_b_imm_i;
  logic        id_reg_write_i, id_mem_read_i, id_mem_write_i;
  logic [4:0]  exm_rd_i, mwb_rd_i;
  logic        exm_reg_write_i, mwb_reg_write_i;
  logic [31:0] exm_result_i, mwb_result_i;
  logic        hazard_o;
  logic [31:0] ScrA, ScrB, ex_store_data_o, ex_pc_o;
  logic [3:0]  ALUControl;
  logic [1:0]  ALUType;
  logic [4:0]  ex_rd_o;
  logic        ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [14:0] ctrl;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .id_pc_i(id_pc_i), .id_imm_i(id_imm_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .id_alu_control_i(id_alu_control_i), .id_alu_type_i(id_alu_type_i),
    .id_src_a_pc_i(id_src_a_pc_i), .id_src_b_imm_i(id_src_b_imm_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .exm_rd_i(exm_rd_i), .exm_reg_write_i(exm_reg_write_i), .exm_result_i(exm_result_i),
    .mwb_rd_i(mwb_rd_i), .mwb_reg_write_i(mwb_reg_write_i), .mwb_result_i(mwb_result_i),
    .hazard_o(hazard_o), .ScrA(ScrA), .ScrB(ScrB), .ALUControl(ALUControl), .ALUType(ALUType),
    .ex_store_data_o(ex_store_data_o), .ex_pc_o(ex_pc_o), .ex_rd_o(ex_rd_o), .ex_valid_o(ex_valid_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o)
  );

  function automatic logic [14:0] mk_ctrl(input logic v, input logic [3:0] c, input logic [1:0] t,
                                          input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
    return {v, c, t, rd, rw, mr, mw};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [14:0] ctrl, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] st);
    exp_t e;
    e.tag = tag; e.ctrl = ctrl; e.pc = pc; e.a = a; e.b = b; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic cmp_now();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_ctrl"}, {17'd0, ex_valid_o, ALUControl, ALUType, ex_rd_o,
                             ex_reg_write_o, ex_mem_read_o, ex_mem_write_o}, {17'd0, e.ctrl});
      chk({e.tag, "_pc"}, ex_pc_o, e.pc);
      chk({e.tag, "_scra"}, ScrA, e.a);
      chk({e.tag, "_scrb"}, ScrB, e.b);
      chk({e.tag, "_store"}, ex_store_data_o, e.st);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cmp_now();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic [3:0] c, input logic [1:0] t,
                       input logic apc, input logic bimm, input logic rw, input logic mr, input logic mw);
    id_valid_i = v; id_pc_i = pc; id_imm_i = imm; id_rs1_data_i = d1; id_rs2_data_i = d2;
    id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd; id_use_rs1_i = u1; id_use_rs2_i = u2;
    id_alu_control_i = c; id_alu_type_i = t; id_src_a_pc_i = apc; id_src_b_imm_i = bimm;
    id_reg_write_i = rw; id_mem_read_i = mr; id_mem_write_i = mw;
  endtask

  task automatic clear_fwd();
    exm_rd_i = 5'd0; exm_reg_write_i = 1'b0; exm_result_i = 32'd0;
    mwb_rd_i = 5'd0; mwb_reg_write_i = 1'b0; mwb_result_i = 32'd0;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive(1, 32'h100, 32'd0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 1, 1, 4'b0010, 2'b00, 0, 0, 1, 0, 0);
    clear_fwd();
    #1;
    push("reset", 15'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    cmp_now();
    chk("reset_hazard", {31'd0, hazard_o}, 32'd0);
    #1 rst = 1'b0;

    // ADD x3,x1,x2 captured on the first edge after reset release
    push("add", mk_ctrl(1, 4'b0010, 2'b00, 5'd3, 1, 0, 0), 32'h100, 32'd5, 32'd7, 32'd7);
    step();

    // asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    push("async_rst", 15'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    cmp_now();
    rst = 1'b0;

    // double forward on rs1=x3
    drive(1, 32'h104, 32'd0, 32'h55, 32'd9, 5'd3, 5'd2, 5'd6, 1, 1, 4'b0010, 2'b00, 0, 0, 1, 0, 0);
    exm_rd_i = 5'd3; exm_reg_write_i = 1'b1; exm_result_i = 32'h10;
    mwb_rd_i = 5'd3; mwb_reg_write_i = 1'b1; mwb_result_i = 32'h20;
    push("fwd_exm", mk_ctrl(1, 4'b0010, 2'b00, 5'd6, 1, 0, 0), 32'h104, 32'h10, 32'd9, 32'd9);
    step();
    exm_reg_write_i = 1'b0;
    #1;
    push("fwd_mwb", mk_ctrl(1, 4'b0010, 2'b00, 5'd6, 1, 0, 0), 32'h104, 32'h20, 32'd9, 32'd9);
    cmp_now();
    exm_reg_write_i = 1'b1; exm_rd_i = 5'd0; mwb_rd_i = 5'd0;
    #1;
    push("fwd_x0", mk_ctrl(1, 4'b0010, 2'b00, 5'd6, 1, 0, 0), 32'h104, 32'h55, 32'd9, 32'd9);
    cmp_now();
    clear_fwd();

    // load-use: LW x4 then ADD x5,x4,x1
    drive(1, 32'h108, 32'd0, 32'h200, 32'd0, 5'd1, 5'd0, 5'd4, 1, 0, 4'b0010, 2'b00, 0, 1, 1, 1, 0);
    push("lw", mk_ctrl(1, 4'b0010, 2'b00, 5'd4, 1, 1, 0), 32'h108, 32'h200, 32'd0, 32'd0);
    step();
    drive(1, 32'h10C, 32'd0, 32'h999, 32'h200, 5'd4, 5'd1, 5'd5, 1, 1, 4'b0010, 2'b00, 0, 0, 1, 0, 0);
    #1;
    chk("loaduse_hazard", {31'd0, hazard_o}, 32'd1);
    push("loaduse_bubble", 15'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    chk("bubble_hazard_clear", {31'd0, hazard_o}, 32'd0);
    exm_rd_i = 5'd4; exm_reg_write_i = 1'b1; exm_result_i = 32'hABC;
    push("loaduse_consumer", mk_ctrl(1, 4'b0010, 2'b00, 5'd5, 1, 0, 0), 32'h10C, 32'hABC, 32'h200, 32'h200);
    step();
    clear_fwd();

    // flush with a load in EX and a dependent BEQ in ID
    drive(1, 32'h110, 32'd0, 32'h200, 32'd0, 5'd1, 5'd0, 5'd4, 1, 0, 4'b0010, 2'b00, 0, 1, 1, 1, 0);
    push("lw2", mk_ctrl(1, 4'b0010, 2'b00, 5'd4, 1, 1, 0), 32'h110, 32'h200, 32'd0, 32'd0);
    step();
    drive(1, 32'h114, 32'd0, 32'd1, 32'd2, 5'd4, 5'd2, 5'd0, 1, 1, 4'b0110, 2'b10, 0, 0, 0, 0, 0);
    flush_i = 1'b1;
    #1;
    chk("flush_hazard", {31'd0, hazard_o}, 32'd0);
    push("flush_bubble", 15'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    flush_i = 1'b0;

    // stall holds for three cycles while id_* changes
    drive(1, 32'h118, 32'd3, 32'h40, 32'd0, 5'd1, 5'd0, 5'd7, 1, 0, 4'b0010, 2'b00, 0, 1, 1, 0, 0);
    push("addi", mk_ctrl(1, 4'b0010, 2'b00, 5'd7, 1, 0, 0), 32'h118, 32'h40, 32'd3, 32'd0);
    step();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h200 + i, 32'h50 + i, 32'h60 + i, 32'h70 + i, 5'd9, 5'd10, 5'd8 + 5'(i),
            1, 1, 4'b0001, 2'b10, 1, 0, 0, 1, 1);
      push("stall_hold", mk_ctrl(1, 4'b0010, 2'b00, 5'd7, 1, 0, 0), 32'h118, 32'h40, 32'd3, 32'd0);
      step();
    end
    stall_i = 1'b0;
    drive(1, 32'h300, 32'd8, 32'd0, 32'h77, 5'd0, 5'd9, 5'd1, 0, 0, 4'b0010, 2'b11, 1, 1, 1, 0, 0);
    push("stall_release", mk_ctrl(1, 4'b0010, 2'b11, 5'd1, 1, 0, 0), 32'h300, 32'h300, 32'd8, 32'h77);
    step();

    // stall together with a load-use hazard: hold without a bubble
    drive(1, 32'h120, 32'd4, 32'h10, 32'd0, 5'd1, 5'd0, 5'd4, 1, 0, 4'b0010, 2'b00, 0, 1, 1, 1, 0);
    push("lw3", mk_ctrl(1, 4'b0010, 2'b00, 5'd4, 1, 1, 0), 32'h120, 32'h10, 32'd4, 32'd0);
    step();
    drive(1, 32'h124, 32'd0, 32'h1, 32'h2, 5'd4, 5'd2, 5'd5, 1, 1, 4'b0010, 2'b00, 0, 0, 1, 0, 0);
    stall_i = 1'b1;
    #1;
    chk("stall_hazard", {31'd0, hazard_o}, 32'd1);
    push("stall_hazard_hold", mk_ctrl(1, 4'b0010, 2'b00, 5'd4, 1, 1, 0), 32'h120, 32'h10, 32'd4, 32'd0);
    step();
    chk("stall_hazard_kept", {31'd0, hazard_o}, 32'd1);
    stall_i = 1'b0;
    push("stall_hazard_bubble", 15'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    push("add_after_bubble", mk_ctrl(1, 4'b0010, 2'b00, 5'd5, 1, 0, 0), 32'h124, 32'h1, 32'h2, 32'h2);
    step();

    // flush and stall together: flush wins
    flush_i = 1'b1; stall_i = 1'b1;
    push("flush_over_stall", 15'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    flush_i = 1'b0; stall_i = 1'b0;

    // SW with immediate ScrB and rs2 forwarded from MEM/WB
    drive(1, 32'h140, 32'd8, 32'h300, 32'h1111, 5'd1, 5'd6, 5'd0, 1, 1, 4'b0010, 2'b01, 0, 1, 0, 0, 1);
    mwb_rd_i = 5'd6; mwb_reg_write_i = 1'b1; mwb_result_i = 32'hDEAD;
    push("sw", mk_ctrl(1, 4'b0010, 2'b01, 5'd0, 0, 0, 1), 32'h140, 32'h300, 32'd8, 32'hDEAD);
    step();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
